stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control and timekeeping sequencer for the stopwatch.
- Consumes single-cycle tick strobes from the clock-divider stage and debounced button/switch levels. All logic runs on clk; no divided clocks are used as clocks.
- Runs a RUN/PAUSED/ADJUST state machine and maintains the mm:ss BCD count.
- Emits per-digit blank mask for the seven-segment scanner.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap (BCD-encodable, ≤99).
- MAX_SEC, 59, highest seconds value before wrap.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle strobe, 1 Hz.
- tick_2hz  in  1  one-cycle strobe, 2 Hz.
- blink  in  1  level, 4 Hz square wave for adjust flashing.
- btn_pause  in  1  debounced level; rising edge toggles run/pause.
- btn_clr  in  1  debounced level; high clears count.
- sw_adj  in  1  adjust mode switch.
- sw_sel  in  1  adjust target: 0 = minutes, 1 = seconds.
- min_tens  out  4  BCD.
- min_ones  out  4  BCD.
- sec_tens  out  4  BCD.
- sec_ones  out  4  BCD.
- digit_blank  out  4  [3]=min_tens .. [0]=sec_ones; 1 = blank.
- running  out  1  high in RUN.

Behaviour:
- Reset (rst=1 at clk edge):
  - All digits 0, digit_blank=0000, state=RUN, running=1.
  - paused_flag=0; btn_pause edge register=0.
- States and transitions:
  - RUN:
    - tick_1hz increments seconds, with carry into minutes.
    - Rising edge of btn_pause -> PAUSED.
    - sw_adj=1 -> ADJUST, recording paused_flag=0.
  - PAUSED:
    - Count frozen.
    - Rising edge of btn_pause -> RUN.
    - sw_adj=1 -> ADJUST, recording paused_flag=1.
  - ADJUST:
    - tick_1hz ignored.
    - tick_2hz increments the selected field only (minutes if sw_sel=0, seconds if sw_sel=1), with no carry between fields.
    - btn_pause edges ignored; the edge register still tracks, so holding the button through exit does not fire.
    - sw_adj=0 -> PAUSED if paused_flag else RUN.
- Priority per cycle: rst > btn_clr > state transition > tick increment.
  - btn_clr: all digits -> 0 next cycle, state unchanged; ticks in the same cycle are discarded.
  - A state transition and a tick in the same cycle: the tick is evaluated under the new state from the next cycle; the coincident tick is dropped.
- Pause edge detection: pause_edge = btn_pause & ~btn_pause_q. btn_pause_q is registered every cycle, including in ADJUST.
- Arithmetic:
  - Seconds wrap MAX_SEC -> 00, with carry to minutes in RUN only.
  - Minutes wrap MAX_MIN -> 00.
  - 59:59 + tick_1hz in RUN -> 00:00 (see optional feature).
  - ones digit 9 -> 0 with tens increment.
  - Digits never leave 0-9; tens ≤ MAX/10.
- digit_blank:
  - In ADJUST with blink=1: the two digits of the selected field are 1, others 0.
  - Otherwise 0000.
  - Registered: one cycle of latency from a blink or sw_sel change.
- running: registered, equals (state==RUN).
- Latency: outputs update on the clk edge following the strobe cycle.

Optional Feature:
- Macro: STOPWATCH_OVF_STOP_EN.
- Defined: in RUN at MAX_MIN:MAX_SEC, tick_1hz holds the count at 59:59 and moves to PAUSED (running=0). btn_clr is needed to restart from 00:00; a pause edge resumes but stays saturated at 59:59.
- Undefined: the count wraps to 00:00 and keeps running.
- ADJUST wrap behaviour is identical either way.

Decomposition:
- stopwatch_pkg holds:
  - state enum {ST_RUN, ST_PAUSED, ST_ADJUST}.
  - BCD digit width constant (4).
  - Default MAX_MIN/MAX_SEC constants.
  - Blank-mask bit index constants.
- One sub-module, bcd_mod_counter:
  - Two BCD digits with parameter MAX.
  - Ports: clk, rst, clr, inc, tens, ones, carry_out (combinational, high when inc at MAX).
  - Instantiated twice: seconds, and minutes (inc = tick carry in RUN, or tick_2hz & select in ADJUST).

Test Plan:
- Reset then 61 tick_1hz strobes in RUN -> 01:01, running=1, digit_blank=0000.
- Preload to 59:59 (via ADJUST), exit adjust, one tick_1hz -> 00:00 without macro; with STOPWATCH_OVF_STOP_EN -> 59:59, running=0.
- Pause edge, then 5 tick_1hz -> count unchanged; second pause edge + 3 ticks -> count +3. Holding btn_pause high for 1000 cycles toggles only once.
- ADJUST sw_sel=1 at 00:58, three tick_2hz -> 00:01 (no minute carry); with blink=1 -> digit_blank=0011 one cycle later; sw_sel=0 -> 1100.
- Enter ADJUST from PAUSED, exit -> PAUSED. Enter from RUN, exit -> RUN. tick_1hz during ADJUST changes nothing.
- btn_clr coincident with tick_1hz at 12:34 -> 00:00 next cycle, state retained; rst asserted mid-ADJUST -> RUN, 00:00, blank=0000.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
//   state_t        : RUN / PAUSED / ADJUST sequencer states
//   DIGIT_W        : width of one BCD digit
//   DEF_MAX_*      : default wrap limits for minutes / seconds
//   BLK_*          : bit positions inside the per-digit blank mask
//   bcd_is         : true when a two-digit BCD pair equals a binary value
package stopwatch_pkg;

   typedef enum logic [1:0] {ST_RUN, ST_PAUSED, ST_ADJUST} state_t;

   localparam int DIGIT_W     = 4;
   localparam int DEF_MAX_MIN = 59;
   localparam int DEF_MAX_SEC = 59;

   localparam int BLK_MIN_TENS = 3;
   localparam int BLK_MIN_ONES = 2;
   localparam int BLK_SEC_TENS = 1;
   localparam int BLK_SEC_ONES = 0;

   function automatic logic bcd_is(input logic [DIGIT_W-1:0] tens,
                                   input logic [DIGIT_W-1:0] ones,
                                   input int                 val);
      return (tens == DIGIT_W'(val / 10)) && (ones == DIGIT_W'(val % 10));
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, counts 00..MAX then wraps to 00.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear to 00
//   inc       : advance by one this cycle
//   tens/ones : BCD digits
//   carry_out : combinational, high when inc arrives while at MAX
module bcd_mod_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               carry_out
);

   logic at_max;

   assign at_max    = bcd_is(tens, ones, MAX);
   assign carry_out = inc & at_max;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tens <= '0;
         ones <= '0;
      end else if (inc) begin
         if (at_max) begin
            tens <= '0;
            ones <= '0;
         end else if (ones == DIGIT_W'(9)) begin
            tens <= tens + DIGIT_W'(1);
            ones <= '0;
         end else begin
            ones <= ones + DIGIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and timekeeping sequencer.
// RUN / PAUSED / ADJUST state machine driving an mm:ss BCD count and the
// per-digit blank mask used for flashing the field being adjusted.
//   clk, rst            : clock, synchronous active-high reset
//   tick_1hz, tick_2hz  : single-cycle strobes (count / adjust rate)
//   blink               : 4 Hz level used for adjust flashing
//   btn_pause           : debounced level, rising edge toggles run/pause
//   btn_clr             : debounced level, clears the count
//   sw_adj, sw_sel      : adjust mode, adjust target (0 = min, 1 = sec)
//   min_*/sec_*         : BCD digits
//   digit_blank         : [3]=min_tens .. [0]=sec_ones, 1 = blank
//   running             : high while in RUN
// Build option: define STOPWATCH_OVF_STOP_EN to saturate at MAX_MIN:MAX_SEC
// and drop to PAUSED instead of wrapping to 00:00 in RUN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN = DEF_MAX_MIN,
   parameter int MAX_SEC = DEF_MAX_SEC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_1hz,
   input  logic               tick_2hz,
   input  logic               blink,
   input  logic               btn_pause,
   input  logic               btn_clr,
   input  logic               sw_adj,
   input  logic               sw_sel,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic [3:0]         digit_blank,
   output logic               running
);

   state_t     state, state_nxt;
   logic       paused_flag, paused_flag_nxt;
   logic       btn_pause_q;
   logic       pause_edge;
   logic       stay;
   logic       run_tick, adj_tick;
   logic       sec_inc, min_inc;
   logic       sec_carry, min_carry;
   logic [3:0] blank_d;

   assign pause_edge = btn_pause & ~btn_pause_q;

   // State register plus registered outputs. The pause edge register
   // tracks the button in every state so a press held across leaving
   // ADJUST cannot fire afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         paused_flag <= 1'b0;
         btn_pause_q <= 1'b0;
         running     <= 1'b1;
         digit_blank <= '0;
      end else begin
         state       <= state_nxt;
         paused_flag <= paused_flag_nxt;
         btn_pause_q <= btn_pause;
         running     <= (state_nxt == ST_RUN);
         digit_blank <= blank_d;
      end
   end

`ifdef STOPWATCH_OVF_STOP_EN
   logic at_max;
   assign at_max = bcd_is(min_tens, min_ones, MAX_MIN) &&
                   bcd_is(sec_tens, sec_ones, MAX_SEC);
`endif

   // Next state. A held clear freezes the state as well as the count.
   always_comb begin
      state_nxt       = state;
      paused_flag_nxt = paused_flag;
      if (!btn_clr) begin
         case (state)
            ST_RUN: begin
               if (sw_adj) begin
                  state_nxt       = ST_ADJUST;
                  paused_flag_nxt = 1'b0;
               end else if (pause_edge) begin
                  state_nxt = ST_PAUSED;
               end
`ifdef STOPWATCH_OVF_STOP_EN
               else if (tick_1hz && at_max) begin
                  // saturate: the tick becomes a transition, count holds
                  state_nxt = ST_PAUSED;
               end
`endif
            end
            ST_PAUSED: begin
               if (sw_adj) begin
                  state_nxt       = ST_ADJUST;
                  paused_flag_nxt = 1'b1;
               end else if (pause_edge) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_ADJUST: begin
               if (!sw_adj) state_nxt = paused_flag ? ST_PAUSED : ST_RUN;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   // Outputs. Ticks only count when the state is not changing this cycle.
   always_comb begin
      stay     = (state_nxt == state);
      run_tick = !btn_clr && stay && (state == ST_RUN)    && tick_1hz;
      adj_tick = !btn_clr && stay && (state == ST_ADJUST) && tick_2hz;
      blank_d  = '0;
      if ((state == ST_ADJUST) && blink) begin
         blank_d[BLK_MIN_TENS] = ~sw_sel;
         blank_d[BLK_MIN_ONES] = ~sw_sel;
         blank_d[BLK_SEC_TENS] = sw_sel;
         blank_d[BLK_SEC_ONES] = sw_sel;
      end
   end

   // Seconds carry reaches minutes only in RUN; adjust edits one field.
   assign sec_inc = run_tick | (adj_tick & sw_sel);
   assign min_inc = (run_tick & sec_carry) | (adj_tick & ~sw_sel);

   bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
      .clk       (clk),
      .rst       (rst),
      .clr       (btn_clr),
      .inc       (sec_inc),
      .tens      (sec_tens),
      .ones      (sec_ones),
      .carry_out (sec_carry)
   );

   bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
      .clk       (clk),
      .rst       (rst),
      .clr       (btn_clr),
      .inc       (min_inc),
      .tens      (min_tens),
      .ones      (min_ones),
      .carry_out (min_carry)
   );

   // Minutes can only wrap through a seconds carry or a direct adjust.
   a_min_wrap_src : assert property (@(posedge clk) disable iff (rst)
      min_carry |-> (sec_carry || (state == ST_ADJUST)));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios with literal
// expectations plus randomized stimulus, all compared every cycle against
// an mm:ss model kept as plain integers.
module tb_stopwatch_ctrl;

   localparam int MAX_MIN = 59;
   localparam int MAX_SEC = 59;
`ifdef STOPWATCH_OVF_STOP_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 0, tick_2hz = 0, blink = 0;
   logic       btn_pause = 0, btn_clr = 0, sw_adj = 0, sw_sel = 0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones, digit_blank;
   logic       running;

   int n_chk  = 0;
   int n_pass = 0;

   stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .blink(blink), .btn_pause(btn_pause), .btn_clr(btn_clr),
      .sw_adj(sw_adj), .sw_sel(sw_sel), .min_tens(min_tens),
      .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .digit_blank(digit_blank), .running(running)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int         m_sec = 0, m_min = 0;
   bit         m_adj = 0, m_paused = 0, m_ret_paused = 0, m_btn_q = 0;
   bit         m_run = 1;
   logic [3:0] m_blank = '0;

   always @(posedge clk) begin : model
      int s, m;
      bit adj, p, rp, edge_seen;
      logic [3:0] b;
      s = m_sec; m = m_min; adj = m_adj; p = m_paused; rp = m_ret_paused;
      b = 4'b0000;
      edge_seen = 1'b0;
      if (rst) begin
         s = 0; m = 0; adj = 0; p = 0; rp = 0;
      end else begin
         edge_seen = btn_pause && !m_btn_q;
         if (adj && blink) b = sw_sel ? 4'b0011 : 4'b1100;
         if (btn_clr) begin
            s = 0; m = 0;
         end else if (adj) begin
            if (!sw_adj) begin
               adj = 0; p = rp;
            end else if (tick_2hz) begin
               if (sw_sel) s = (s + 1) % (MAX_SEC + 1);
               else        m = (m + 1) % (MAX_MIN + 1);
            end
         end else if (sw_adj) begin
            rp = p; adj = 1;
         end else if (edge_seen) begin
            p = !p;
         end else if (!p && tick_1hz) begin
            if (OVF && s == MAX_SEC && m == MAX_MIN) p = 1;
            else begin
               s = s + 1;
               if (s > MAX_SEC) begin
                  s = 0; m = (m + 1) % (MAX_MIN + 1);
               end
            end
         end
      end
      m_sec        <= s;
      m_min        <= m;
      m_adj        <= adj;
      m_paused     <= p;
      m_ret_paused <= rp;
      m_btn_q      <= rst ? 1'b0 : btn_pause;
      m_run        <= !adj && !p;
      m_blank      <= b;
   end

   function automatic void chk(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [15:0] digits();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      chk("model_digits", digits(),
          {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)});
      chk("model_blank", 16'(digit_blank), 16'(m_blank));
      chk("model_running", 16'(running), 16'(m_run));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick1(input int n);
      repeat (n) begin tick_1hz = 1; step(1); tick_1hz = 0; step(1); end
   endtask

   task automatic tick2(input int n);
      repeat (n) begin tick_2hz = 1; step(1); tick_2hz = 0; step(1); end
   endtask

   task automatic press_pause();
      btn_pause = 1; step(1); btn_pause = 0; step(1);
   endtask

   initial begin
      step(2);
      rst = 0;
      chk("reset_digits", digits(), 16'h0000);
      chk("reset_running", 16'(running), 16'h1);
      chk("reset_blank", 16'(digit_blank), 16'h0);

      tick1(61);
      chk("count_61", digits(), 16'h0101);
      chk("count_61_running", 16'(running), 16'h1);
      chk("count_61_blank", 16'(digit_blank), 16'h0);

      // preload 59:59 through ADJUST (entered from RUN)
      sw_adj = 1; step(1);
      sw_sel = 0; tick2(58);
      sw_sel = 1; tick2(58);
      sw_adj = 0; step(1);
      chk("preload", digits(), 16'h5959);
      chk("preload_running", 16'(running), 16'h1);
      tick1(1);
      if (OVF) begin
         chk("ovf_hold", digits(), 16'h5959);
         chk("ovf_paused", 16'(running), 16'h0);
         press_pause();
         tick1(1);
         chk("ovf_saturated", digits(), 16'h5959);
         btn_clr = 1; step(1); btn_clr = 0; step(1);
         chk("ovf_clr", digits(), 16'h0000);
         press_pause();
      end else begin
         chk("wrap", digits(), 16'h0000);
         chk("wrap_running", 16'(running), 16'h1);
      end

      // pause / resume
      tick1(3);
      press_pause();
      chk("paused_running", 16'(running), 16'h0);
      tick1(5);
      chk("paused_frozen", digits(), 16'h0003);
      press_pause();
      tick1(3);
      chk("resumed_count", digits(), 16'h0006);
      btn_pause = 1; step(1000); btn_pause = 0; step(1);
      chk("hold_toggles_once", 16'(running), 16'h0);
      press_pause();

      // adjust seconds with no minute carry, blank mask
      tick1(52);
      sw_adj = 1; sw_sel = 1; step(1);
      tick2(3);
      chk("adj_no_carry", digits(), 16'h0001);
      blink = 1; step(1);
      chk("blank_sec", 16'(digit_blank), 16'h3);
      sw_sel = 0; step(1);
      chk("blank_min", 16'(digit_blank), 16'hC);
      tick1(2);
      chk("adj_ignores_1hz", digits(), 16'h0001);
      blink = 0; step(1);
      chk("blank_off", 16'(digit_blank), 16'h0);
      sw_adj = 0; step(1);
      chk("exit_to_run", 16'(running), 16'h1);
      press_pause();
      sw_adj = 1; step(1);
      sw_adj = 0; step(1);
      chk("exit_to_paused", 16'(running), 16'h0);
      press_pause();

      // clear coincident with tick at 12:34
      sw_adj = 1; sw_sel = 0; step(1);
      tick2(12);
      sw_sel = 1; tick2(33);
      sw_adj = 0; step(1);
      chk("preload_1234", digits(), 16'h1234);
      btn_clr = 1; tick_1hz = 1; step(1); btn_clr = 0; tick_1hz = 0;
      chk("clr_with_tick", digits(), 16'h0000);
      chk("clr_keeps_state", 16'(running), 16'h1);

      // reset in the middle of ADJUST
      sw_adj = 1; sw_sel = 1; blink = 1; step(2);
      chk("pre_rst_blank", 16'(digit_blank), 16'h3);
      rst = 1; sw_adj = 0; blink = 0; step(1); rst = 0;
      chk("rst_adj_digits", digits(), 16'h0000);
      chk("rst_adj_running", 16'(running), 16'h1);
      chk("rst_adj_blank", 16'(digit_blank), 16'h0);

      // randomized traffic, checked by the model each cycle
      for (int i = 0; i < 3000; i++) begin
         tick_1hz = ($urandom_range(0, 3) == 0);
         tick_2hz = ($urandom_range(0, 3) == 0);
         blink    = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
         btn_clr  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 49) == 0) sw_adj = ~sw_adj;
         if ($urandom_range(0, 19) == 0) sw_sel = ~sw_sel;
         rst      = ($urandom_range(0, 499) == 0);
         step(1);
      end

      {tick_1hz, tick_2hz, blink, btn_pause, btn_clr, sw_adj, sw_sel, rst} = '0;
      step(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
